phy_tx_serializer: RTL and testbench



---
 rtl/phy_tx_serializer.sv | 118 +++++++++++
 tb/tb_phy_tx_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_serializer.sv
// Transmit PHY serializer: four byte-wide lane buffers interleaved round-robin
// into one MSB-first bit stream, preceded by a COM training burst after reset.
module phy_tx_serializer #(
  parameter logic [7:0] COM_SYM   = 8'hBC,
  parameter logic [7:0] IDLE_SYM  = 8'h7C,
  parameter int         COM_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  output logic       ready_out0,
  output logic       ready_out1,
  output logic       ready_out2,
  output logic       ready_out3,
  output logic       data_out,
  output logic       sym_start,
  output logic       active_out
);

  localparam logic [3:0] COM_LIMIT = 4'(COM_COUNT);

  typedef enum logic {TRAIN, DATA} state_t;

  state_t      state, state_nxt;
  logic [3:0]  com_cnt, com_cnt_nxt;
  logic [1:0]  lane_ptr, lane_ptr_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  next_sym;
  logic        boundary;
  logic        load_slot;
  logic [7:0]  lane_buf [4];
  logic [7:0]  lane_data [4];
  logic [3:0]  valid, ready, full, full_nxt, accept, drain;

  assign lane_data[0] = data_in0;
  assign lane_data[1] = data_in1;
  assign lane_data[2] = data_in2;
  assign lane_data[3] = data_in3;
  assign valid        = {valid_in3, valid_in2, valid_in1, valid_in0};
  assign ready_out0   = ready[0];
  assign ready_out1   = ready[1];
  assign ready_out2   = ready[2];
  assign ready_out3   = ready[3];

  assign boundary = (bit_cnt == 3'd7);
  // The boundary that ends the COM burst already carries the lane-0 data slot.
  assign load_slot = boundary && ((state == DATA) || (com_cnt == COM_LIMIT));
  assign accept   = valid & ready;

  always_comb begin
    state_nxt    = state;
    com_cnt_nxt  = com_cnt;
    lane_ptr_nxt = lane_ptr;
    next_sym     = IDLE_SYM;
    drain        = '0;
    if (load_slot) begin
      state_nxt    = DATA;
      lane_ptr_nxt = lane_ptr + 2'd1;
      if (full[lane_ptr]) begin
        next_sym        = lane_buf[lane_ptr];
        drain[lane_ptr] = 1'b1;
      end
    end else if (boundary) begin
      next_sym    = COM_SYM;
      com_cnt_nxt = com_cnt + 4'd1;
    end
    full_nxt = (full & ~drain) | accept;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= TRAIN;
      com_cnt    <= '0;
      lane_ptr   <= '0;
      bit_cnt    <= 3'd7;
      shift      <= '0;
      data_out   <= 1'b0;
      sym_start  <= 1'b0;
      active_out <= 1'b0;
      full       <= '0;
      ready      <= '0;
    end else begin
      state      <= state_nxt;
      com_cnt    <= com_cnt_nxt;
      lane_ptr   <= lane_ptr_nxt;
      active_out <= (state_nxt == DATA);
      full       <= full_nxt;
      ready      <= ~full_nxt;
      if (boundary) begin
        data_out  <= next_sym[7];
        shift     <= {next_sym[6:0], 1'b0};
        bit_cnt   <= 3'd0;
        sym_start <= 1'b1;
      end else begin
        data_out  <= shift[7];
        shift     <= {shift[6:0], 1'b0};
        bit_cnt   <= bit_cnt + 3'd1;
        sym_start <= 1'b0;
      end
    end
  end

  // Payload registers carry no reset; the full flags alone say whether they hold data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) lane_buf[i] <= lane_data[i];
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed bench for phy_tx_serializer: training burst, lane slots, backpressure, reset.
module tb_phy_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       valid_in0, valid_in1, valid_in2, valid_in3;
  logic       ready_out0, ready_out1, ready_out2, ready_out3;
  logic       data_out, sym_start, active_out;

  int checks = 0;
  int fails  = 0;

  phy_tx_serializer dut (
    .clk(clk), .reset(reset),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
    .ready_out0(ready_out0), .ready_out1(ready_out1), .ready_out2(ready_out2), .ready_out3(ready_out3),
    .data_out(data_out), .sym_start(sym_start), .active_out(active_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Collect one symbol; valids in 'pulse' are held only across the first edge.
  task automatic get_sym(input logic [3:0] pulse, output logic [7:0] sym,
                         output logic [7:0] ss, output logic act, output logic [3:0] rdy);
    {valid_in3, valid_in2, valid_in1, valid_in0} = pulse;
    sym = '0;
    ss  = '0;
    act = 1'b0;
    rdy = '0;
    for (int b = 0; b < 8; b++) begin
      step();
      if (b == 0) begin
        {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
        act = active_out;
        rdy = {ready_out3, ready_out2, ready_out1, ready_out0};
      end
      sym = {sym[6:0], data_out};
      ss  = {ss[6:0], sym_start};
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
    repeat (3) step();
    checks++;
    if ({data_out, sym_start, active_out} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000", {data_out, sym_start, active_out});
    end
    checks++;
    if ({ready_out3, ready_out2, ready_out1, ready_out0} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 0000", {ready_out3, ready_out2, ready_out1, ready_out0});
    end
    reset = 1'b1;
  endtask

  task automatic test_train();
    logic [7:0] sym, ss;
    logic       act;
    logic [3:0] rdy;
    for (int s = 0; s < 6; s++) begin
      get_sym(4'b0000, sym, ss, act, rdy);
      checks++;
      if (sym !== ((s < 4) ? 8'hBC : 8'h7C)) begin
        fails++;
        $display("FAIL train_sym%0d: got %h expected %h", s, sym, (s < 4) ? 8'hBC : 8'h7C);
      end
      checks++;
      if (ss !== 8'h80) begin
        fails++;
        $display("FAIL train_symstart%0d: got %b expected 10000000", s, ss);
      end
      checks++;
      if (act !== (s >= 4)) begin
        fails++;
        $display("FAIL train_active%0d: got %b expected %b", s, act, (s >= 4));
      end
      if (s == 0) begin
        checks++;
        if (rdy !== 4'b1111) begin
          fails++;
          $display("FAIL ready_after_release: got %b expected 1111", rdy);
        end
      end
    end
  endtask

  task automatic test_single_lane0();
    logic [7:0] sym, ss;
    logic       act;
    logic [3:0] rdy;
    do_reset();
    get_sym(4'b0000, sym, ss, act, rdy);
    data_in0 = 8'hA5;
    get_sym(4'b0001, sym, ss, act, rdy);
    checks++;
    if (rdy[0] !== 1'b0) begin
      fails++;
      $display("FAIL lane0_ready_drop: got %b expected 0", rdy[0]);
    end
    get_sym(4'b0000, sym, ss, act, rdy);
    get_sym(4'b0000, sym, ss, act, rdy);
    checks++;
    if (sym !== 8'hBC) begin
      fails++;
      $display("FAIL lane0_com4: got %h expected bc", sym);
    end
    for (int s = 0; s < 4; s++) begin
      get_sym(4'b0000, sym, ss, act, rdy);
      checks++;
      if (sym !== ((s == 0) ? 8'hA5 : 8'h7C)) begin
        fails++;
        $display("FAIL lane0_data_slot%0d: got %h expected %h", s, sym, (s == 0) ? 8'hA5 : 8'h7C);
      end
      if (s == 0) begin
        checks++;
        if (rdy[0] !== 1'b1 || act !== 1'b1) begin
          fails++;
          $display("FAIL lane0_ready_return: got ready=%b active=%b expected 1 1", rdy[0], act);
        end
      end
    end
  endtask

  task automatic test_all_lanes();
    logic [7:0] sym, ss;
    logic       act;
    logic [3:0] rdy;
    logic [7:0] expv [8];
    expv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h7C, 8'h7C, 8'h7C, 8'h7C};
    repeat (3) get_sym(4'b0000, sym, ss, act, rdy);
    data_in0 = 8'h11; data_in1 = 8'h22; data_in2 = 8'h33; data_in3 = 8'h44;
    get_sym(4'b1111, sym, ss, act, rdy);
    checks++;
    if (sym !== 8'h7C || rdy !== 4'b0000) begin
      fails++;
      $display("FAIL all_lanes_capture: got sym=%h ready=%b expected 7c 0000", sym, rdy);
    end
    for (int s = 0; s < 8; s++) begin
      get_sym(4'b0000, sym, ss, act, rdy);
      checks++;
      if (sym !== expv[s]) begin
        fails++;
        $display("FAIL all_lanes_sym%0d: got %h expected %h", s, sym, expv[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sym, expd;
    logic       r, v;
    int         acc = 0;
    data_in2  = 8'h01;
    valid_in2 = 1'b1;
    for (int s = 0; s < 12; s++) begin
      sym = '0;
      for (int b = 0; b < 8; b++) begin
        r = ready_out2;
        v = valid_in2;
        step();
        sym = {sym[6:0], data_out};
        if (v && r) begin
          acc++;
          if (acc == 1) data_in2 = 8'h02;
          else valid_in2 = 1'b0;
        end
      end
      expd = 8'h7C;
      if (s == 2) expd = 8'h01;
      if (s == 6) expd = 8'h02;
      checks++;
      if (sym !== expd) begin
        fails++;
        $display("FAIL backpressure_sym%0d: got %h expected %h", s, sym, expd);
      end
    end
    checks++;
    if (acc !== 2) begin
      fails++;
      $display("FAIL backpressure_accepts: got %0d expected 2", acc);
    end
    valid_in2 = 1'b0;
  endtask

  task automatic test_com_verbatim();
    logic [7:0] sym, ss;
    logic       act;
    logic [3:0] rdy;
    data_in3 = 8'hBC;
    for (int s = 0; s < 4; s++) begin
      get_sym((s == 0) ? 4'b1000 : 4'b0000, sym, ss, act, rdy);
      checks++;
      if (sym !== ((s == 3) ? 8'hBC : 8'h7C) || act !== 1'b1) begin
        fails++;
        $display("FAIL verbatim_sym%0d: got %h active=%b expected %h active=1",
                 s, sym, act, (s == 3) ? 8'hBC : 8'h7C);
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    logic [7:0] sym, ss;
    logic       act;
    logic [3:0] rdy;
    data_in3 = 8'h5A;
    get_sym(4'b1000, sym, ss, act, rdy);
    repeat (4) step();
    reset = 1'b0;
    step();
    checks++;
    if ({data_out, active_out, ready_out3, ready_out2, ready_out1, ready_out0} !== 6'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b expected 000000",
               {data_out, active_out, ready_out3, ready_out2, ready_out1, ready_out0});
    end
    repeat (2) step();
    reset = 1'b1;
    data_in0 = 8'h3C;
    for (int s = 0; s < 8; s++) begin
      get_sym((s == 1) ? 4'b0001 : 4'b0000, sym, ss, act, rdy);
      checks++;
      if (sym !== ((s < 4) ? 8'hBC : (s == 4) ? 8'h3C : 8'h7C) || ss !== 8'h80) begin
        fails++;
        $display("FAIL midreset_sym%0d: got %h symstart=%b expected %h 10000000",
                 s, sym, ss, (s < 4) ? 8'hBC : (s == 4) ? 8'h3C : 8'h7C);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
    test_reset();
    test_train();
    test_single_lane0();
    test_all_lanes();
    test_back_to_back();
    test_com_verbatim();
    test_reset_mid_symbol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
